// File: rtl/thermostat_fsm_p.sv
// Hysteresis thermostat: programmable thresholds, minimum dwell, fault state with debounced exit.
// Latency: one clock from a valid sample to the registered state and enable outputs.
// No backpressure: a sample is consumed on every edge where temp_valid is high.
module thermostat_fsm_p #(
  parameter int WIDTH     = 5,
  parameter int MIN_DWELL = 4,
  parameter int FAULT_CLR = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] temp,
  input  logic             temp_valid,
  input  logic [WIDTH-1:0] heat_on_th,
  input  logic [WIDTH-1:0] heat_off_th,
  input  logic [WIDTH-1:0] cool_on_th,
  input  logic [WIDTH-1:0] cool_off_th,
  input  logic [WIDTH-1:0] fault_lo,
  input  logic [WIDTH-1:0] fault_hi,
  output logic             heat_en,
  output logic             cool_en,
  output logic [1:0]       state,
  output logic             dwell_busy,
  output logic [CNT_W-1:0] trans_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COOL  = 2'b01,
    S_HEAT  = 2'b10,
    S_FAULT = 2'b11
  } state_t;

  // Counters sized to hold their largest value; a width of at least one bit is guaranteed by the +1.
  localparam int DW = $clog2(MIN_DWELL + 1);
  localparam int CW = $clog2(FAULT_CLR + 1);
  localparam logic [DW-1:0] DWELL_LOAD = DW'(MIN_DWELL);
  // The clear count never stores FAULT_CLR itself: the sample that would reach it exits FAULT.
  localparam logic [CW-1:0] CLR_LAST   = CW'(FAULT_CLR - 1);

  state_t          cur;
  state_t          nxt;
  logic [DW-1:0]   dwell_cnt;
  logic [CW-1:0]   clr_cnt;
  logic [CW-1:0]   clr_nxt;
  logic            out_of_range;

  assign out_of_range = (temp < fault_lo) || (temp > fault_hi);
  assign dwell_busy   = (dwell_cnt != '0);
  assign state        = cur;

  // Next-state and fault-clear bookkeeping; the range check overrides dwell in every non-fault state.
  always_comb begin
    nxt     = cur;
    clr_nxt = clr_cnt;
    if (temp_valid) begin
      if (cur == S_FAULT) begin
        if (out_of_range) begin
          clr_nxt = '0;
        end else if (clr_cnt == CLR_LAST) begin
          nxt     = S_IDLE;
          clr_nxt = '0;
        end else begin
          clr_nxt = clr_cnt + CW'(1);
        end
      end else if (out_of_range) begin
        nxt     = S_FAULT;
        clr_nxt = '0;
      end else if (!dwell_busy) begin
        case (cur)
          S_IDLE: begin
            // Heating wins when the on-thresholds overlap.
            if (temp <= heat_on_th)      nxt = S_HEAT;
            else if (temp >= cool_on_th) nxt = S_COOL;
          end
          S_HEAT:  if (temp >= heat_off_th) nxt = S_IDLE;
          S_COOL:  if (temp <= cool_off_th) nxt = S_IDLE;
          default: nxt = cur;
        endcase
      end
    end
  end

  // State, dwell timer, transition counter and registered enables; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= S_IDLE;
      dwell_cnt <= '0;
      clr_cnt   <= '0;
      trans_cnt <= '0;
      heat_en   <= 1'b0;
      cool_en   <= 1'b0;
    end else begin
      cur     <= nxt;
      clr_cnt <= clr_nxt;
      if (nxt != cur) begin
        // Fault entry leaves the timer idle so the fault exit path is never held off.
        dwell_cnt <= (nxt == S_FAULT) ? '0 : DWELL_LOAD;
        if (trans_cnt != '1) trans_cnt <= trans_cnt + CNT_W'(1);
      end else if (dwell_cnt != '0) begin
        dwell_cnt <= dwell_cnt - DW'(1);
      end
      heat_en <= (nxt == S_HEAT);
      cool_en <= (nxt == S_COOL);
    end
  end

endmodule

// File: tb/tb_thermostat_fsm_p.sv
// Bench for thermostat_fsm_p: two builds (dwell 4 and dwell 1) share one stimulus stream.
// A behavioural model tracks both and is compared every cycle; directed literals pin the model.
module tb_thermostat_fsm_p;

  localparam int WIDTH = 5;
  localparam int CNT_W = 8;
  localparam int FCLR  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] temp = '0;
  logic             temp_valid = 1'b0;
  logic [WIDTH-1:0] heat_on_th  = 5'd12;
  logic [WIDTH-1:0] heat_off_th = 5'd20;
  logic [WIDTH-1:0] cool_on_th  = 5'd18;
  logic [WIDTH-1:0] cool_off_th = 5'd14;
  logic [WIDTH-1:0] fault_lo    = 5'd2;
  logic [WIDTH-1:0] fault_hi    = 5'd30;

  logic             heat_en0, cool_en0, busy0;
  logic [1:0]       state0;
  logic [CNT_W-1:0] trans0;
  logic             heat_en1, cool_en1, busy1;
  logic [1:0]       state1;
  logic [CNT_W-1:0] trans1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  thermostat_fsm_p #(.WIDTH(WIDTH), .MIN_DWELL(4), .FAULT_CLR(FCLR), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .temp(temp), .temp_valid(temp_valid),
    .heat_on_th(heat_on_th), .heat_off_th(heat_off_th),
    .cool_on_th(cool_on_th), .cool_off_th(cool_off_th),
    .fault_lo(fault_lo), .fault_hi(fault_hi),
    .heat_en(heat_en0), .cool_en(cool_en0), .state(state0),
    .dwell_busy(busy0), .trans_cnt(trans0)
  );

  thermostat_fsm_p #(.WIDTH(WIDTH), .MIN_DWELL(1), .FAULT_CLR(FCLR), .CNT_W(CNT_W)) dut_fast (
    .clk(clk), .rst(rst), .temp(temp), .temp_valid(temp_valid),
    .heat_on_th(heat_on_th), .heat_off_th(heat_off_th),
    .cool_on_th(cool_on_th), .cool_off_th(cool_off_th),
    .fault_lo(fault_lo), .fault_hi(fault_hi),
    .heat_en(heat_en1), .cool_en(cool_en1), .state(state1),
    .dwell_busy(busy1), .trans_cnt(trans1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: state codes 0 idle, 1 cool, 2 heat, 3 fault; one entry per build.
  int m_st[2];
  int m_dw[2];
  int m_cl[2];
  int m_tc[2];
  int md[2] = '{4, 1};
  bit model_ok = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int nst;
      bit bad_range;
      if (rst) begin
        m_st[i] = 0; m_dw[i] = 0; m_cl[i] = 0; m_tc[i] = 0;
        model_ok = 1'b1;
      end else begin
        nst = m_st[i];
        if (temp_valid) begin
          bad_range = (int'(temp) < int'(fault_lo)) || (int'(temp) > int'(fault_hi));
          if (m_st[i] == 3) begin
            if (bad_range) m_cl[i] = 0;
            else begin
              m_cl[i] = m_cl[i] + 1;
              if (m_cl[i] == FCLR) begin nst = 0; m_cl[i] = 0; end
            end
          end else if (bad_range) nst = 3;
          else if (m_dw[i] == 0) begin
            if (m_st[i] == 0) begin
              if (temp <= heat_on_th) nst = 2;
              else if (temp >= cool_on_th) nst = 1;
            end else if (m_st[i] == 2 && temp >= heat_off_th) nst = 0;
            else if (m_st[i] == 1 && temp <= cool_off_th) nst = 0;
          end
        end
        if (nst != m_st[i]) begin
          m_tc[i] = (m_tc[i] < 255) ? m_tc[i] + 1 : 255;
          m_dw[i] = (nst == 3) ? 0 : md[i];
        end else if (m_dw[i] > 0) m_dw[i] = m_dw[i] - 1;
        m_st[i] = nst;
      end
    end
  end

  // Every-cycle comparison of both builds against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("m0_state", state0, m_st[0]);
      chk("m0_heat", heat_en0, m_st[0] == 2);
      chk("m0_cool", cool_en0, m_st[0] == 1);
      chk("m0_busy", busy0, m_dw[0] != 0);
      chk("m0_trans", trans0, m_tc[0]);
      chk("m0_excl", heat_en0 & cool_en0, 0);
      chk("m1_state", state1, m_st[1]);
      chk("m1_heat", heat_en1, m_st[1] == 2);
      chk("m1_cool", cool_en1, m_st[1] == 1);
      chk("m1_busy", busy1, m_dw[1] != 0);
      chk("m1_trans", trans1, m_tc[1]);
      chk("m1_excl", heat_en1 & cool_en1, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int vv[6] = '{1, 0, 1, 1, 1, 1};
    int tt[6] = '{15, 5, 16, 1, 15, 16};

    // Reset
    tick();
    rst = 1'b0;
    chk("rst_state", state0, 0);
    chk("rst_heat", heat_en0, 0);
    chk("rst_cool", cool_en0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_trans", trans0, 0);

    // IDLE -> COOL on 18
    temp_valid = 1'b1; temp = 5'd18;
    tick();
    chk("cool_state", state0, 1);
    chk("cool_en", cool_en0, 1);
    chk("cool_busy", busy0, 1);
    chk("cool_trans", trans0, 1);

    // 10 during dwell is held off, then COOL -> IDLE -> HEAT
    temp = 5'd10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dwell_hold_state", state0, 1);
      chk("dwell_hold_busy", busy0, 1);
    end
    tick();
    chk("dwell_done_state", state0, 1);
    chk("dwell_done_busy", busy0, 0);
    tick();
    chk("to_idle_state", state0, 0);
    chk("to_idle_trans", trans0, 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_dwell_state", state0, 0);
    end
    tick();
    chk("heat_state", state0, 2);
    chk("heat_en", heat_en0, 1);
    chk("heat_cool_off", cool_en0, 0);
    chk("heat_trans", trans0, 3);

    // Out of range during dwell -> FAULT immediately
    temp = 5'd31;
    tick();
    chk("fault_state", state0, 3);
    chk("fault_heat", heat_en0, 0);
    chk("fault_busy", busy0, 0);
    chk("fault_trans", trans0, 4);

    // Debounced exit: the low sample restarts the count
    for (int i = 0; i < 6; i++) begin
      temp_valid = vv[i][0]; temp = 5'(tt[i]);
      tick();
      chk("fault_hold", state0, 3);
    end
    temp_valid = 1'b1; temp = 5'd17;
    tick();
    chk("fault_exit_state", state0, 0);
    chk("fault_exit_trans", trans0, 5);
    chk("fault_exit_busy", busy0, 1);

    // Invalid samples never move the state
    temp_valid = 1'b0; temp = 5'd5;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("invalid_hold", state0, 0);
    end
    temp_valid = 1'b1;
    tick();
    chk("valid_heat", state0, 2);
    chk("valid_heat_trans", trans0, 6);

    // HEAT -> IDLE -> COOL on 25, then reset mid-dwell
    temp = 5'd25;
    for (int i = 0; i < 10; i++) tick();
    chk("via_idle_cool", state0, 1);
    chk("via_idle_trans", trans0, 8);
    tick();
    chk("pre_rst_busy", busy0, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_state", state0, 0);
    chk("mid_rst_heat", heat_en0, 0);
    chk("mid_rst_cool", cool_en0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_trans", trans0, 0);
    rst = 1'b0;

    // Saturation: alternating samples drive the dwell-1 build past 255 transitions
    for (int i = 0; i < 1200; i++) begin
      temp = (i % 2) ? 5'd25 : 5'd10;
      tick();
    end
    chk("sat_trans", trans1, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/thermostat_fsm_p.md
Name: thermostat_fsm_p

Overview:
- Clocked, parametrised hysteresis thermostat controller.
- Consumes validated temperature samples and drives mutually exclusive heat and cool enables.
- Adds run-time programmable thresholds, a minimum-dwell timer, a sensor-fault state with debounced recovery, and a saturating transition counter.
- Sits between the sensor sampling block and the actuator drivers.

Parameters:
- WIDTH, 5, bit width of temperature and all threshold inputs (unsigned).
- MIN_DWELL, 4, clock cycles a non-fault state must be held before a non-fault transition is allowed (≥1).
- FAULT_CLR, 3, consecutive valid in-range samples required to leave FAULT (≥1).
- CNT_W, 8, width of the transition counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- temp  in  WIDTH  temperature sample, unsigned.
- temp_valid  in  1  temp is sampled on this cycle only when high.
- heat_on_th  in  WIDTH  IDLE→HEAT when temp ≤ this.
- heat_off_th  in  WIDTH  HEAT→IDLE when temp ≥ this.
- cool_on_th  in  WIDTH  IDLE→COOL when temp ≥ this.
- cool_off_th  in  WIDTH  COOL→IDLE when temp ≤ this.
- fault_lo  in  WIDTH  sample is out of range if temp < fault_lo.
- fault_hi  in  WIDTH  sample is out of range if temp > fault_hi.
- heat_en  out  1  heater enable.
- cool_en  out  1  cooler enable.
- state  out  2  IDLE=00, COOL=01, HEAT=10, FAULT=11.
- dwell_busy  out  1  dwell counter nonzero; non-fault transitions are blocked.
- trans_cnt  out  CNT_W  count of state changes, saturating.

Behaviour:
- Reset: synchronous, active-high, wins over everything.
  - state=IDLE; heat_en=0; cool_en=0; dwell cnt=0, dwell_busy=0; fault-clear cnt=0; trans_cnt=0.
- All outputs are registered and update on the same edge as state. heat_en = (state==HEAT); cool_en = (state==COOL); never both 1.
- Samples are evaluated only on edges where temp_valid=1. temp_valid=0 → state holds. The dwell counter still decrements.
- Fault check runs first, on every valid sample, in any non-FAULT state, regardless of dwell. temp<fault_lo or temp>fault_hi → FAULT on that edge.
- Non-fault transitions are allowed only when the dwell counter is 0:
  - IDLE: temp ≤ heat_on_th → HEAT; else temp ≥ cool_on_th → COOL; else stay. HEAT has priority if both hold.
  - HEAT: temp ≥ heat_off_th → IDLE.
  - COOL: temp ≤ cool_off_th → IDLE.
  - No direct HEAT↔COOL path; the change must pass through IDLE.
- FAULT exit:
  - Each valid in-range sample increments the clear count; each valid out-of-range sample resets it to 0. Invalid cycles leave it unchanged.
  - On the valid sample that makes the count reach FAULT_CLR → IDLE, and the count clears.
  - Dwell does not apply in FAULT.
- Dwell counter:
  - Loaded with MIN_DWELL on every edge where state changes into IDLE/HEAT/COOL.
  - Otherwise decrements by 1 per cycle while nonzero.
  - dwell_busy = (cnt != 0).
  - On entry to FAULT it is loaded with 0.
- trans_cnt: +1 on every edge where state changes; saturates at all-ones.
- Thresholds are combinational inputs read every sample. Mid-operation changes take effect on the next valid sample; no re-ordering or checking is done.
- Reset asserted mid-dwell or mid-fault-clear aborts both and returns to the reset values on that edge.
- Comparisons are unsigned, WIDTH bits, with no wrap-around arithmetic.

Test Plan (defaults, thresholds heat_on=12 heat_off=20 cool_on=18 cool_off=14 fault_lo=2 fault_hi=30):
- Reset then valid temp=18 → next edge state=01, cool_en=1, dwell_busy=1 for 4 cycles, trans_cnt=1.
- In COOL, valid temp=10 while dwell_busy=1 → state stays 01. Hold temp=10 valid → IDLE on the first edge with dwell=0. Four cycles later → HEAT. trans_cnt=3. Check that cool_en and heat_en are never high together.
- In HEAT, valid temp=31 with dwell_busy=1 → FAULT on that edge, heat_en=0. Then valid 15, invalid, 16, 1, 15, 16, 17 → stays FAULT until the third consecutive in-range valid sample (17), then IDLE.
- IDLE with temp_valid=0 and temp=5 for 10 cycles → no state change. Raise valid → HEAT.
- Force 2^CNT_W+5 transitions (e.g. MIN_DWELL=1 bench build) → trans_cnt sticks at 255.
- Assert rst mid-dwell in COOL → next edge state=00, all outputs 0, dwell_busy=0.
